usb_string_desc_reader: RTL

USB_STRING_DESC_READER -- requirements
Module: usb_string_desc_reader

---
 rtl/usb_string_desc_reader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_string_desc_reader.sv
// Streams a USB string descriptor out of a combinational ROM as IN packets, with NAK resend.
// Define USB_STR_ZLP_EN to send a zero-length packet after a short transfer that ends on a packet boundary.
module usb_string_desc_reader #(
    parameter int MAX_PACKET  = 64,
    parameter int NUM_STRINGS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_index,
    input  logic [15:0] req_wlength,
    input  logic        abort,
    output logic [7:0]  str_index,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_length,
    input  logic [7:0]  rom_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_last,
    output logic        tx_zlp,
    input  logic        pkt_ack,
    input  logic        pkt_nak,
    output logic        stall,
    output logic        xfer_done
);

    localparam int PW = $clog2(MAX_PACKET);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PACKET - 1);

`ifdef USB_STR_ZLP_EN
    localparam bit ZLP_EN = 1'b1;
`else
    localparam bit ZLP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        SEND,
        WAIT_ACK,
        ZLP,
        DONE
    } state_t;

    state_t        r_state;
    logic [7:0]    r_index;
    logic [15:0]   r_wlength;
    logic [7:0]    r_total;
    logic [7:0]    r_byte_ptr;
    logic [7:0]    r_pkt_start;
    logic [CW-1:0] r_pkt_cnt;
    logic          r_zlp_flag;
    logic          r_tx_valid;
    logic          r_tx_last;
    logic          r_tx_zlp;
    logic          r_stall;
    logic          r_xfer_done;

    logic          w_valid_index;
    logic [7:0]    w_min_len;
    logic          w_zlp_needed;
    logic          w_accept;

    // tx_last is registered, so it is precomputed for the byte that will be offered next.
    function automatic logic isLast(input logic [7:0] ptr, input logic [CW-1:0] cnt,
                                    input logic [7:0] total);
        return (cnt == LAST_CNT) || (ptr == total - 8'd1);
    endfunction

    assign w_valid_index = (32'(r_index) < NUM_STRINGS);
    assign w_min_len     = ({8'd0, rom_length} < r_wlength) ? rom_length : r_wlength[7:0];
    assign w_zlp_needed  = ZLP_EN && (r_total[PW-1:0] == '0) && ({8'd0, r_total} < r_wlength);
    assign w_accept      = r_tx_valid && tx_ready;

    assign req_ready = (r_state == IDLE);
    assign str_index = r_index;
    assign rom_addr  = r_byte_ptr;
    assign tx_data   = rom_data;
    assign tx_valid  = r_tx_valid;
    assign tx_last   = r_tx_last;
    assign tx_zlp    = ZLP_EN && r_tx_zlp;
    assign stall     = r_stall;
    assign xfer_done = r_xfer_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_index     <= 8'd0;
            r_wlength   <= 16'd0;
            r_total     <= 8'd0;
            r_byte_ptr  <= 8'd0;
            r_pkt_start <= 8'd0;
            r_pkt_cnt   <= '0;
            r_zlp_flag  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_tx_zlp    <= 1'b0;
            r_stall     <= 1'b0;
            r_xfer_done <= 1'b0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_zlp_flag  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_tx_zlp    <= 1'b0;
            r_stall     <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_stall     <= 1'b0;
            r_xfer_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_index   <= req_index;
                        r_wlength <= req_wlength;
                        r_state   <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (!w_valid_index) begin
                        r_stall <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_total     <= w_min_len;
                        r_byte_ptr  <= 8'd0;
                        r_pkt_start <= 8'd0;
                        r_pkt_cnt   <= '0;
                        r_zlp_flag  <= 1'b0;
                        if (w_min_len == 8'd0) begin
                            r_xfer_done <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_tx_valid <= 1'b1;
                            r_tx_last  <= isLast(8'd0, '0, w_min_len);
                            r_state    <= SEND;
                        end
                    end
                end

                SEND: begin
                    if (w_accept) begin
                        r_byte_ptr <= r_byte_ptr + 8'd1;
                        r_pkt_cnt  <= r_pkt_cnt + CW'(1);
                        if (r_tx_last) begin
                            r_tx_valid <= 1'b0;
                            r_tx_last  <= 1'b0;
                            r_state    <= WAIT_ACK;
                        end else begin
                            r_tx_last <= isLast(r_byte_ptr + 8'd1, r_pkt_cnt + CW'(1), r_total);
                        end
                    end
                end

                // A NAK rewinds to the start of the packet just sent, whether data or ZLP.
                WAIT_ACK: begin
                    if (pkt_nak) begin
                        r_byte_ptr <= r_pkt_start;
                        r_pkt_cnt  <= '0;
                        r_tx_valid <= 1'b1;
                        if (r_zlp_flag) begin
                            r_tx_last <= 1'b1;
                            r_tx_zlp  <= 1'b1;
                            r_state   <= ZLP;
                        end else begin
                            r_tx_last <= isLast(r_pkt_start, '0, r_total);
                            r_state   <= SEND;
                        end
                    end else if (pkt_ack) begin
                        if (r_zlp_flag) begin
                            r_xfer_done <= 1'b1;
                            r_state     <= DONE;
                        end else if (r_byte_ptr < r_total) begin
                            r_pkt_start <= r_byte_ptr;
                            r_pkt_cnt   <= '0;
                            r_tx_valid  <= 1'b1;
                            r_tx_last   <= isLast(r_byte_ptr, '0, r_total);
                            r_state     <= SEND;
                        end else if (w_zlp_needed) begin
                            r_pkt_start <= r_byte_ptr;
                            r_pkt_cnt   <= '0;
                            r_tx_valid  <= 1'b1;
                            r_tx_last   <= 1'b1;
                            r_tx_zlp    <= 1'b1;
                            r_state     <= ZLP;
                        end else begin
                            r_xfer_done <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end

                ZLP: begin
                    if (w_accept) begin
                        r_zlp_flag <= 1'b1;
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        r_tx_zlp   <= 1'b0;
                        r_state    <= WAIT_ACK;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
